// File: rtl/mc_cpu_pkg.sv
// Shared constants and types for the multi-cycle control unit.
// Opcode/ALU encodings, FSM states, PC source codes and decode bundle.
package mc_cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_ROT  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_ROT = 3'd6;
  localparam logic [2:0] ALU_SUB = 3'd7;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] alu;
    logic       rtype;
    logic       addi;
    logic       ld;
    logic       st;
    logic       bne;
    logic       jmp;
    logic       nop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational opcode decoder producing the control bundle.
// Opcodes 0xD-0xF flag illegal.
module mc_cu_decode
  import mc_cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl     = '0;
    ctrl.alu = ALU_ADD;
    unique case (1'b1)
      opcode == OP_ADD:  ctrl.rtype = 1'b1;
      opcode == OP_ADDI: ctrl.addi  = 1'b1;
      opcode == OP_OR: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_OR;
      end
      opcode == OP_AND: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_AND;
      end
      opcode == OP_XOR: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_XOR;
      end
      opcode == OP_NOR: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_NOR;
      end
      opcode == OP_SLL: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_SLL;
      end
      opcode == OP_ROT: begin
        ctrl.rtype = 1'b1;
        ctrl.alu   = ALU_ROT;
      end
      opcode == OP_BNE: begin
        ctrl.bne = 1'b1;
        ctrl.alu = ALU_SUB;
      end
      opcode == OP_LD:  ctrl.ld  = 1'b1;
      opcode == OP_ST:  ctrl.st  = 1'b1;
      opcode == OP_JMP: ctrl.jmp = 1'b1;
      opcode == OP_NOP: ctrl.nop = 1'b1;
      default:          ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: FSM, opcode latch, retire counter.
// Define MC_CU_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module mc_control_unit
  import mc_cpu_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int ALUCTL_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                alusrc,
  output logic                regdst,
  output logic                regwrite,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                trap,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic [2:0]          state
);

  state_t     st_q;
  state_t     st_d;
  logic [3:0] op_q;
  logic [3:0] op_in;
  ctrl_t      c;
  logic       retire;
  logic [2:0] alu3;
  logic       unused_instr;

  assign op_in        = instr[INSTR_W-1 -: 4];
  assign unused_instr = ^instr[INSTR_W-5:0];
  assign state        = st_q;

  mc_cu_decode u_dec (
    .opcode (op_q),
    .ctrl   (c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_FETCH;
      op_q      <= OP_NOP;
      instr_cnt <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_FETCH && instr_valid)
        op_q <= op_in;
      if (retire)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    st_d   = st_q;
    retire = 1'b0;
    unique case (st_q)
      S_FETCH:
        if (instr_valid) st_d = S_DECODE;
      S_DECODE:
        if (c.nop || c.jmp) begin
          st_d   = S_FETCH;
          retire = 1'b1;
        end else if (c.illegal) begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
          st_d = S_TRAP;
`else
          st_d   = S_FETCH;
          retire = 1'b1;
`endif
        end else begin
          st_d = S_EXEC;
        end
      S_EXEC:
        if (c.bne) begin
          st_d   = S_FETCH;
          retire = 1'b1;
        end else if (c.ld || c.st) begin
          st_d = S_MEM;
        end else begin
          st_d = S_WB;
        end
      S_MEM:
        if (mem_ack) begin
          st_d   = c.st ? S_FETCH : S_WB;
          retire = c.st;
        end
      S_WB: begin
        st_d   = S_FETCH;
        retire = 1'b1;
      end
      S_TRAP:  st_d = S_TRAP;
      default: st_d = S_FETCH;
    endcase
  end

  // FETCH outputs are gated by rst_n so reset forces every strobe low
  always_comb begin
    instr_ready = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_INC;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    alusrc      = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alu3        = ALU_ADD;
    unique case (st_q)
      S_FETCH: begin
        instr_ready = rst_n;
        ir_we       = rst_n & instr_valid;
        pc_we       = rst_n & instr_valid;
      end
      S_DECODE: begin
        alu3 = c.alu;
        if (c.jmp) begin
          pc_we  = 1'b1;
          pc_src = PC_JMP;
        end
      end
      S_EXEC: begin
        alu3   = c.alu;
        regdst = c.rtype;
        alusrc = c.addi | c.ld | c.st;
        if (c.bne && !zero) begin
          pc_we  = 1'b1;
          pc_src = PC_BR;
        end
      end
      S_MEM: begin
        alu3     = c.alu;
        mem_req  = 1'b1;
        alusrc   = 1'b1;
        memwrite = c.st;
      end
      S_WB: begin
        alu3     = c.alu;
        regwrite = 1'b1;
        memtoreg = c.ld;
        regdst   = c.rtype;
      end
      default: ;
    endcase
  end

  assign alucontrol = ALUCTL_W'(alu3);

`ifdef MC_CU_ILLEGAL_TRAP_EN
  assign trap = (st_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with a retire-count scoreboard.
// Honors MC_CU_ILLEGAL_TRAP_EN when the design is built with it.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        memwrite;
  logic        memtoreg;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [3:0]  alucontrol;
  logic        trap;
  logic [3:0]  instr_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  logic [3:0] model_cnt = 4'd0;
  logic [3:0] sb[$];

  mc_control_unit #(
    .INSTR_W  (16),
    .ALUCTL_W (4),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .zero        (zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .alusrc      (alusrc),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .alucontrol  (alucontrol),
    .trap        (trap),
    .instr_cnt   (instr_cnt),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op);
    instr       = {op, 12'h123};
    instr_valid = 1'b1;
    @(negedge clk);
    chk("fetch_state", state, 0);
    chk("fetch_ready", instr_ready, 1);
    chk("fetch_ir_we", ir_we, 1);
    chk("fetch_pc_we", pc_we, 1);
    chk("fetch_pc_src", pc_src, 0);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic expect_retire();
    model_cnt = model_cnt + 4'd1;
    sb.push_back(model_cnt);
  endtask

  task automatic pop_check(input string tag);
    int n = 0;
    logic [3:0] exp;
    while (state != 3'd0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_reach_fetch"}, (n < 20), 1);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_cnt"}, instr_cnt, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    zero        = 1'b0;
    mem_ack     = 1'b0;
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_cnt", instr_cnt, 0);
    chk("rst_trap", trap, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_regwrite", regwrite, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_alu", alucontrol, 0);
    rst_n = 1'b1;

    // ADD
    fetch(4'h0);
    @(negedge clk);
    chk("add_dec_state", state, 1);
    chk("add_dec_ir_we", ir_we, 0);
    chk("add_dec_alu", alucontrol, 0);
    tick();
    @(negedge clk);
    chk("add_ex_state", state, 2);
    chk("add_ex_regdst", regdst, 1);
    chk("add_ex_alusrc", alusrc, 0);
    chk("add_ex_alu", alucontrol, 0);
    chk("add_ex_regwrite", regwrite, 0);
    tick();
    @(negedge clk);
    chk("add_wb_regwrite", regwrite, 1);
    chk("add_wb_regdst", regdst, 1);
    chk("add_wb_memtoreg", memtoreg, 0);
    expect_retire();
    tick();
    pop_check("add");
    chk("add_after_regwrite", regwrite, 0);

    // remaining R-type ops
    for (int op = 2; op <= 7; op++) begin
      fetch(op[3:0]);
      tick();
      @(negedge clk);
      chk("r_ex_alu", alucontrol, op - 1);
      chk("r_ex_regdst", regdst, 1);
      tick();
      @(negedge clk);
      chk("r_wb_regwrite", regwrite, 1);
      chk("r_wb_alu", alucontrol, op - 1);
      expect_retire();
      tick();
      pop_check("rtype");
    end

    // ADDI, with instr_valid held outside FETCH
    fetch(4'h1);
    instr       = 16'hB000;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("addi_dec_ir_we", ir_we, 0);
    tick();
    @(negedge clk);
    chk("addi_ex_state", state, 2);
    chk("addi_ex_alusrc", alusrc, 1);
    chk("addi_ex_regdst", regdst, 0);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    chk("addi_wb_regwrite", regwrite, 1);
    chk("addi_wb_regdst", regdst, 0);
    expect_retire();
    tick();
    pop_check("addi");

    // LD with three wait cycles
    fetch(4'h9);
    tick();
    @(negedge clk);
    chk("ld_ex_alusrc", alusrc, 1);
    chk("ld_ex_mem_req", mem_req, 0);
    tick();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk("ld_wait_state", state, 3);
      chk("ld_wait_mem_req", mem_req, 1);
      chk("ld_wait_memwrite", memwrite, 0);
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("ld_ack_mem_req", mem_req, 1);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("ld_wb_state", state, 4);
    chk("ld_wb_regwrite", regwrite, 1);
    chk("ld_wb_memtoreg", memtoreg, 1);
    chk("ld_wb_mem_req", mem_req, 0);
    expect_retire();
    tick();
    pop_check("ld");
    chk("ld_after_regwrite", regwrite, 0);

    // ST with stray mem_ack before MEM
    fetch(4'hA);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_dec_state", state, 1);
    tick();
    @(negedge clk);
    chk("st_ex_state", state, 2);
    chk("st_ex_alusrc", alusrc, 1);
    mem_ack = 1'b0;
    tick();
    @(negedge clk);
    chk("st_mem_req", mem_req, 1);
    chk("st_memwrite", memwrite, 1);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_ack_state", state, 3);
    chk("st_regwrite", regwrite, 0);
    expect_retire();
    tick();
    mem_ack = 1'b0;
    pop_check("st");

    // BNE taken and not taken
    fetch(4'h8);
    tick();
    zero = 1'b0;
    @(negedge clk);
    chk("bne_t_pc_we", pc_we, 1);
    chk("bne_t_pc_src", pc_src, 1);
    chk("bne_t_alu", alucontrol, 7);
    chk("bne_t_alusrc", alusrc, 0);
    expect_retire();
    tick();
    pop_check("bne_taken");
    fetch(4'h8);
    tick();
    zero = 1'b1;
    @(negedge clk);
    chk("bne_nt_pc_we", pc_we, 0);
    expect_retire();
    tick();
    zero = 1'b0;
    pop_check("bne_not_taken");

    // JMP
    fetch(4'hB);
    @(negedge clk);
    chk("jmp_pc_we", pc_we, 1);
    chk("jmp_pc_src", pc_src, 2);
    expect_retire();
    tick();
    pop_check("jmp");

    // illegal opcode
    fetch(4'hE);
`ifdef MC_CU_ILLEGAL_TRAP_EN
    tick();
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'b1;
      @(negedge clk);
      chk("trap_flag", trap, 1);
      chk("trap_ready", instr_ready, 0);
      chk("trap_state", state, 5);
      chk("trap_ir_we", ir_we, 0);
      tick();
    end
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("trap_rst_flag", trap, 0);
    chk("trap_rst_state", state, 0);
    chk("trap_rst_cnt", instr_cnt, 0);
    model_cnt = 4'd0;
    tick();
    rst_n = 1'b1;
`else
    @(negedge clk);
    chk("ill_trap", trap, 0);
    chk("ill_pc_we", pc_we, 0);
    expect_retire();
    tick();
    pop_check("illegal_nop");
`endif

    // 16 NOPs walk the 4-bit counter through its wrap
    for (int i = 0; i < 16; i++) begin
      fetch(4'hC);
      @(negedge clk);
      chk("nop_pc_we", pc_we, 0);
      expect_retire();
      tick();
      pop_check("nop");
    end

    // reset during MEM of a store
    fetch(4'hA);
    tick();
    tick();
    @(negedge clk);
    chk("strst_mem_req_pre", mem_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("strst_mem_req", mem_req, 0);
    chk("strst_state", state, 0);
    chk("strst_cnt", instr_cnt, 0);
    chk("strst_alu", alucontrol, 0);
    model_cnt = 4'd0;
    tick();
    rst_n = 1'b1;
    fetch(4'hC);
    expect_retire();
    tick();
    pop_check("post_rst_nop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
